// File: rtl/reset_seq_ctrl.sv
// Board-level reset sequencer.
// Synchronises the raw KEY buttons and the PLL lock flag, debounces the keys,
// holds every downstream domain in reset until the PLL is locked and a settle
// period has passed, then releases the domains one at a time (stage 0 first).
// Also drives a status LED (heartbeat once running, solid otherwise) and a
// single-cycle pulse for each accepted KEY[1] press.
module reset_seq_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned STRETCH_CYC  = 1024,
  parameter int unsigned STAGE_GAP    = 256,
  parameter int unsigned N_STAGES     = 3,
  parameter int unsigned HB_DIV       = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          key,
  input  logic                pll_locked,
  output logic [N_STAGES-1:0] rst_out,
  output logic                sys_ready,
  output logic                status_led,
  output logic                key1_pulse
);

  // Counter widths: each counter only ever reaches its limit minus one.
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC) + 1;
  localparam int unsigned TMR_MAX = (STRETCH_CYC > STAGE_GAP) ? STRETCH_CYC : STAGE_GAP;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int unsigned HB_W    = $clog2(HB_DIV) + 1;

  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] STRETCH_LAST = TMR_W'(STRETCH_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(STAGE_GAP - 1);
  localparam logic [HB_W-1:0]  HB_LAST      = HB_W'(HB_DIV - 1);

  // Reset pattern right after stage 0 releases; all zero when there is only
  // one stage, which sends the FSM straight to RUN.
  localparam logic [N_STAGES-1:0] FIRST_REL = ~N_STAGES'(1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_LOCK,
    S_STRETCH,
    S_REL,
    S_RUN
  } state_t;

  state_t            state;
  logic [1:0]        key_meta;
  logic [1:0]        key_sync;
  logic              lock_meta;
  logic              lock_sync;
  logic [1:0]        key_acc;
  logic [DB_W-1:0]   db_cnt [2];
  logic [TMR_W-1:0]  tmr;
  logic [HB_W-1:0]   hb_cnt;
  logic              hb;
  logic              abort;
  logic [N_STAGES-1:0] rst_shift;

  // Two-flop synchronisers for the asynchronous board inputs.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta  <= 2'b11;
      key_sync  <= 2'b11;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      key_meta  <= key;
      key_sync  <= key_meta;
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // Per-key debouncer: a new level is accepted only after it has differed
  // from the accepted level for DEBOUNCE_CYC consecutive cycles.
  // The KEY[1] press pulse rises on the same edge the press is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this two-entry counter array is plain flops, so it is reset in
      // a loop like any other register; large RAM-style arrays would not be.
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
      key_acc    <= 2'b11;
      key1_pulse <= 1'b0;
    end else begin
      key1_pulse <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (key_sync[i] == key_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]  <= '0;
          key_acc[i] <= key_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      if (key_acc[1] && !key_sync[1] && (db_cnt[1] == DB_LAST)) begin
        key1_pulse <= 1'b1;
      end
    end
  end

  // Any active stage drops back to HOLD when KEY[0] is pressed or lock is lost.
  assign abort = !key_acc[0] || !lock_sync;

  // Releasing the next stage is a left shift: bits clear strictly in order
  // from stage 0 upwards, so a later stage can never release before an earlier one.
  assign rst_shift = rst_out << 1;

  // Sequencer FSM with registered reset and ready outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      rst_out   <= '1;
      sys_ready <= 1'b0;
      tmr       <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          rst_out   <= '1;
          sys_ready <= 1'b0;
          tmr       <= '0;
          if (key_acc[0]) begin
            state <= S_LOCK;
          end
        end

        // Waiting for lock is not an abort; only a key press leaves here early.
        S_LOCK: begin
          tmr <= '0;
          if (!key_acc[0]) begin
            state <= S_HOLD;
          end else if (lock_sync) begin
            state <= S_STRETCH;
          end
        end

        S_STRETCH: begin
          if (abort) begin
            state     <= S_HOLD;
            rst_out   <= '1;
            sys_ready <= 1'b0;
            tmr       <= '0;
          end else if (tmr == STRETCH_LAST) begin
            tmr     <= '0;
            rst_out <= FIRST_REL;
            if (FIRST_REL == '0) begin
              state     <= S_RUN;
              sys_ready <= 1'b1;
            end else begin
              state <= S_REL;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_REL: begin
          if (abort) begin
            state     <= S_HOLD;
            rst_out   <= '1;
            sys_ready <= 1'b0;
            tmr       <= '0;
          end else if (tmr == GAP_LAST) begin
            tmr     <= '0;
            rst_out <= rst_shift;
            if (rst_shift == '0) begin
              state     <= S_RUN;
              sys_ready <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_RUN: begin
          if (abort) begin
            state     <= S_HOLD;
            rst_out   <= '1;
            sys_ready <= 1'b0;
            tmr       <= '0;
          end else begin
            rst_out   <= '0;
            sys_ready <= 1'b1;
          end
        end

        default: begin
          state     <= S_HOLD;
          rst_out   <= '1;
          sys_ready <= 1'b0;
          tmr       <= '0;
        end
      endcase
    end
  end

  // Free-running heartbeat divider; only the board reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  // LED blinks only while running; solid on otherwise so a stuck sequence is visible.
  assign status_led = (state == S_RUN) ? hb : 1'b1;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Self-checking bench for reset_seq_ctrl with small timing parameters.
module tb_reset_seq_ctrl;

  localparam int unsigned DEBOUNCE_CYC = 4;
  localparam int unsigned STRETCH_CYC  = 8;
  localparam int unsigned STAGE_GAP    = 4;
  localparam int unsigned N_STAGES     = 3;
  localparam int unsigned HB_DIV       = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          key;
  logic                pll_locked;
  logic [N_STAGES-1:0] rst_out;
  logic                sys_ready;
  logic                status_led;
  logic                key1_pulse;

  int n_cmp = 0;
  int n_err = 0;

  reset_seq_ctrl #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .STRETCH_CYC (STRETCH_CYC),
    .STAGE_GAP   (STAGE_GAP),
    .N_STAGES    (N_STAGES),
    .HB_DIV      (HB_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .pll_locked(pll_locked),
    .rst_out   (rst_out),
    .sys_ready (sys_ready),
    .status_led(status_led),
    .key1_pulse(key1_pulse)
  );

  always #5 clk = ~clk;

  // One vector: drive inputs, advance adv clock edges, then compare.
  typedef struct {
    int         adv;
    logic [1:0] key;
    logic       lock;
    logic [2:0] exp_rst;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int adv, input logic [1:0] k, input logic l,
                     input logic [2:0] r, input logic y);
    vec_t v;
    v.adv = adv; v.key = k; v.lock = l; v.exp_rst = r; v.exp_ready = y;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and park on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      key        = vecs[i].key;
      pll_locked = vecs[i].lock;
      tick(vecs[i].adv);
      check($sformatf("vec%0d rst_out", i), rst_out, vecs[i].exp_rst);
      check($sformatf("vec%0d sys_ready", i), sys_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d key1_pulse", i), key1_pulse, 1'b0);
      if (!vecs[i].exp_ready) check($sformatf("vec%0d status_led", i), status_led, 1'b1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rst_out"}, rst_out, 3'b111);
    check({tag, " sys_ready"}, sys_ready, 1'b0);
    check({tag, " status_led"}, status_led, 1'b1);
    check({tag, " key1_pulse"}, key1_pulse, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, first_pulse, cyc, toggles, last_t;
    logic prev;

    // Rows 0-7: power-up sequence, lock already high (STRETCH entered at edge 3).
    add(1, 2'b11, 1'b1, 3'b111, 1'b0);
    add(9, 2'b11, 1'b1, 3'b111, 1'b0);
    add(1, 2'b11, 1'b1, 3'b110, 1'b0);
    add(3, 2'b11, 1'b1, 3'b110, 1'b0);
    add(1, 2'b11, 1'b1, 3'b100, 1'b0);
    add(3, 2'b11, 1'b1, 3'b100, 1'b0);
    add(1, 2'b11, 1'b1, 3'b000, 1'b1);
    add(5, 2'b11, 1'b1, 3'b000, 1'b1);
    // Rows 8-9: 2-cycle KEY[0] glitch is rejected.
    add(2, 2'b10, 1'b1, 3'b000, 1'b1);
    add(8, 2'b11, 1'b1, 3'b000, 1'b1);
    // Rows 10-12: KEY[0] held; accepted at edge 6, all resets reassert at edge 7.
    add(6, 2'b10, 1'b1, 3'b000, 1'b1);
    add(1, 2'b10, 1'b1, 3'b111, 1'b0);
    add(3, 2'b10, 1'b1, 3'b111, 1'b0);
    // Rows 13-18: release; accept at 6, LOCK at 7, STRETCH at 8, stages at 16/20/24.
    add(15, 2'b11, 1'b1, 3'b111, 1'b0);
    add(1, 2'b11, 1'b1, 3'b110, 1'b0);
    add(3, 2'b11, 1'b1, 3'b110, 1'b0);
    add(1, 2'b11, 1'b1, 3'b100, 1'b0);
    add(3, 2'b11, 1'b1, 3'b100, 1'b0);
    add(1, 2'b11, 1'b1, 3'b000, 1'b1);
    // Rows 19-21: lock lost in RUN, abort on edge 3, then wait in LOCK.
    add(2, 2'b11, 1'b0, 3'b000, 1'b1);
    add(1, 2'b11, 1'b0, 3'b111, 1'b0);
    add(5, 2'b11, 1'b0, 3'b111, 1'b0);
    // Rows 22-23: relock, STRETCH at edge 3, stage 0 releases at edge 11.
    add(10, 2'b11, 1'b1, 3'b111, 1'b0);
    add(1, 2'b11, 1'b1, 3'b110, 1'b0);
    // Rows 24-26: lock lost in REL, all stages reassert together.
    add(2, 2'b11, 1'b0, 3'b110, 1'b0);
    add(1, 2'b11, 1'b0, 3'b111, 1'b0);
    add(3, 2'b11, 1'b0, 3'b111, 1'b0);
    // Rows 27-32: relock, full 8+4+4 sequence again.
    add(10, 2'b11, 1'b1, 3'b111, 1'b0);
    add(1, 2'b11, 1'b1, 3'b110, 1'b0);
    add(3, 2'b11, 1'b1, 3'b110, 1'b0);
    add(1, 2'b11, 1'b1, 3'b100, 1'b0);
    add(3, 2'b11, 1'b1, 3'b100, 1'b0);
    add(1, 2'b11, 1'b1, 3'b000, 1'b1);

    rst_n      = 1'b0;
    key        = 2'b11;
    pll_locked = 1'b1;
    tick(3);
    check_reset_values("reset");
    rst_n = 1'b1;

    apply(0, 32);

    // KEY[1] press with release bounce: exactly one 1-cycle pulse ~6 cycles in.
    pulses = 0; first_pulse = -1; cyc = 0;
    key = 2'b01;
    for (int c = 0; c < 20; c++) begin
      tick(1); cyc++;
      if (key1_pulse) begin pulses++; if (first_pulse < 0) first_pulse = cyc; end
    end
    for (int b = 0; b < 6; b++) begin
      key = (b % 2 == 0) ? 2'b11 : 2'b01;
      tick(1); cyc++;
      if (key1_pulse) pulses++;
    end
    key = 2'b11;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (key1_pulse) pulses++;
    end
    check("key1 pulse cycles", pulses, 1);
    check("key1 pulse delay in 5..8", (first_pulse >= 5 && first_pulse <= 8), 1'b1);
    check("key1 rst_out untouched", rst_out, 3'b000);
    check("key1 sys_ready kept", sys_ready, 1'b1);

    // Heartbeat in RUN: 6 toggles in 30 cycles, spaced exactly 5 apart.
    prev = status_led; toggles = 0; last_t = -1;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (status_led !== prev) begin
        toggles++;
        if (last_t >= 0) check("heartbeat spacing", c - last_t, HB_DIV);
        last_t = c;
        prev = status_led;
      end
    end
    check("heartbeat toggles", toggles, 6);

    // Async reset while running: outputs snap to reset values mid-cycle.
    #2 rst_n = 1'b0;
    #1 check_reset_values("async in RUN");
    check("async in RUN status_led was heartbeat-free", status_led, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 6);

    // LOCK state: LED solid on.
    pll_locked = 1'b0;
    tick(4);
    check("lock loss rst_out", rst_out, 3'b111);
    toggles = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (status_led !== 1'b1) toggles++;
    end
    check("led solid in LOCK", toggles, 0);

    // Async reset mid-STRETCH, then the whole sequence restarts from HOLD.
    pll_locked = 1'b1;
    tick(6);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async in STRETCH");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
